// File: rtl/riscv_memsys.sv
// riscv_memsys: byte-stream program loader with instruction/data memories serving one hart.
// Define RISCV_MEMSYS_FAULT_EN to enable misaligned/out-of-range access faulting.
module riscv_memsys #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     WORDS     = 256,
    parameter logic [XLEN-1:0] HALT_ADDR = 32'hFFFF_FFFC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    input  logic [7:0]      ld_data,
    input  logic            ld_last,
    output logic            ld_ready,
    output logic            hart_rst,
    input  logic [XLEN-1:0] pc,
    output logic [31:0]     instruction,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            mem_write,
    output logic [XLEN-1:0] mem_read,
    output logic            done,
    output logic            fault,
    output logic [31:0]     cycles
);
    localparam int unsigned IDXW = $clog2(WORDS);
    localparam int unsigned CNTW = IDXW + 2;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] byte_cnt_q, byte_cnt_d;
    logic            ld_full_q, ld_full_d;
    logic [31:0]     asm_q, asm_d;
    logic [31:0]     instruction_q, instruction_d;
    logic [XLEN-1:0] mem_read_q, mem_read_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;
    logic [31:0]     cycles_q, cycles_d;

    logic [31:0] imem [WORDS];
    logic [31:0] dmem [WORDS];

    logic            imem_we, dmem_we;
    logic [IDXW-1:0] imem_widx;
    logic [31:0]     imem_wdata, dmem_wdata;

    logic [IDXW-1:0] pc_idx, da_idx;
    logic            halt_wr, pc_bad, da_bad, ld_fire;

    assign pc_idx   = pc[IDXW+1:2];
    assign da_idx   = mem_addr[IDXW+1:2];
    assign halt_wr  = mem_write && (mem_addr == HALT_ADDR);
    assign ld_ready = (state_q == S_LOAD) && !rst;
    assign ld_fire  = ld_valid && ld_ready;
    assign hart_rst = rst || (state_q != S_RUN);

`ifdef RISCV_MEMSYS_FAULT_EN
    assign pc_bad = (pc[1:0] != 2'b00) || (pc[XLEN-1:IDXW+2] != '0);
    assign da_bad = !halt_wr &&
                    ((mem_addr[1:0] != 2'b00) || (mem_addr[XLEN-1:IDXW+2] != '0));
`else
    logic unused_addr_bits;
    assign pc_bad = 1'b0;
    assign da_bad = 1'b0;
    assign unused_addr_bits = ^{pc[XLEN-1:IDXW+2], pc[1:0],
                                mem_addr[XLEN-1:IDXW+2], mem_addr[1:0]};
`endif

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        ld_full_d     = ld_full_q;
        asm_d         = asm_q;
        instruction_d = '0;
        mem_read_d    = mem_read_q;
        done_d        = done_q;
        fault_d       = fault_q;
        cycles_d      = cycles_q;
        imem_we       = 1'b0;
        imem_widx     = byte_cnt_q[CNTW-1:2];
        imem_wdata    = asm_q | (32'(ld_data) << {byte_cnt_q[1:0], 3'b000});
        dmem_we       = 1'b0;
        dmem_wdata    = mem_data[31:0];

        unique case (state_q)
            S_LOAD: begin
                if (ld_fire) begin
                    // Once the byte counter has wrapped past the last word, bytes are dropped.
                    if (!ld_full_q) begin
                        if (byte_cnt_q[1:0] == 2'd3 || ld_last) begin
                            imem_we = 1'b1;
                            asm_d   = '0;
                        end else begin
                            asm_d = imem_wdata;
                        end
                        byte_cnt_d = byte_cnt_q + CNTW'(1);
                        if (byte_cnt_q == '1) ld_full_d = 1'b1;
                    end
                    if (ld_last) state_d = S_RUN;
                end
            end
            S_RUN: begin
                cycles_d = cycles_q + 32'd1;
                if (!pc_bad) instruction_d = imem[pc_idx];
                if (halt_wr) begin
                    done_d  = 1'b1;
                    state_d = S_HALT;
                end else if (!(pc_bad || da_bad)) begin
                    if (mem_write) dmem_we = 1'b1;
                    else           mem_read_d = XLEN'(dmem[da_idx]);
                end
                if (pc_bad || da_bad) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_HALT: ;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            byte_cnt_q    <= '0;
            ld_full_q     <= 1'b0;
            asm_q         <= '0;
            instruction_q <= '0;
            mem_read_q    <= '0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
            cycles_q      <= '0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            ld_full_q     <= ld_full_d;
            asm_q         <= asm_d;
            instruction_q <= instruction_d;
            mem_read_q    <= mem_read_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            cycles_q      <= cycles_d;
        end
    end

    // Memories carry no reset so their contents survive rst and reloads.
    always_ff @(posedge clk) begin
        if (imem_we && !rst) imem[imem_widx] <= imem_wdata;
        if (dmem_we && !rst) dmem[da_idx] <= dmem_wdata;
    end

    assign instruction = instruction_q;
    assign mem_read    = mem_read_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign cycles      = cycles_q;
endmodule

// File: tb/tb_riscv_memsys.sv
// Bench for riscv_memsys: vector table, hand-written corner sequences and randomized
// fetch/data traffic compared against an array-based reference model.
`timescale 1ns/1ps
module tb_riscv_memsys;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned WORDS     = 256;
    localparam logic [31:0] HALT_ADDR = 32'hFFFF_FFFC;
    localparam int unsigned NO_GAP    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, ld_valid, ld_last, ld_ready, hart_rst, mem_write, done, fault;
    logic [7:0]  ld_data;
    logic [31:0] pc, instruction, mem_addr, mem_data, mem_read, cycles;

    always #5 clk = ~clk;

    riscv_memsys #(.XLEN(XLEN), .WORDS(WORDS), .HALT_ADDR(HALT_ADDR)) u_dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .hart_rst(hart_rst), .pc(pc), .instruction(instruction),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
        .mem_read(mem_read), .done(done), .fault(fault), .cycles(cycles)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
        bit          chk;
        logic [31:0] exp_rd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog_m [WORDS];
    logic [31:0] dmem_m [WORDS];
    bit          dmem_known [WORDS];
    logic [31:0] last_rd_m;
    int unsigned cyc_m;
    logic [7:0]  ld_bytes [$];
    vec_t        vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle();
        tick();
        cyc_m++;
    endtask

    // Streams ld_bytes into the loader; the model packs bytes little-endian per word.
    task automatic load_stream(input int unsigned gap_at);
        int unsigned n;
        n = ld_bytes.size();
        for (int unsigned i = 0; i < n; i++) begin
            if (i < WORDS * 4) begin
                if (i % 4 == 0) prog_m[i / 4] = '0;
                prog_m[i / 4] = prog_m[i / 4] | (32'(ld_bytes[i]) << (8 * (i % 4)));
            end
        end
        for (int unsigned i = 0; i < n; i++) begin
            if (i == gap_at) begin
                ld_valid = 1'b0; ld_data = 8'hFF; ld_last = 1'b1;
                tick();
            end
            ld_valid = 1'b1;
            ld_data  = ld_bytes[i];
            ld_last  = (i == n - 1);
            if (i == n - 1) check("hart_rst_at_last", hart_rst, 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("hart_rst_after_last", hart_rst, 0);
        check("ld_ready_in_run", ld_ready, 0);
        check("cycles_run_start", cycles, 0);
        cyc_m = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w, p;
        bit          wr;

        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        pc = '0; mem_addr = '0; mem_data = '0; mem_write = 1'b0;
        cyc_m = 0; last_rd_m = '0;
        for (int unsigned i = 0; i < WORDS; i++) dmem_known[i] = 1'b0;

        vt[0] = '{1'b1, 32'h000, 32'hCAFEF00D, 32'h00, 1'b0, 32'h0};
        vt[1] = '{1'b1, 32'h010, 32'hDEADBEEF, 32'h04, 1'b0, 32'h0};
        vt[2] = '{1'b0, 32'h010, 32'h0,        32'h08, 1'b1, 32'hDEADBEEF};
        vt[3] = '{1'b1, 32'h014, 32'h12345678, 32'h0C, 1'b1, 32'hDEADBEEF};
        vt[4] = '{1'b0, 32'h014, 32'h0,        32'h1C, 1'b1, 32'h12345678};
        vt[5] = '{1'b1, 32'h3FC, 32'h55AA55AA, 32'h00, 1'b1, 32'h12345678};
        vt[6] = '{1'b0, 32'h000, 32'h0,        32'h04, 1'b1, 32'hCAFEF00D};
        vt[7] = '{1'b0, 32'h3FC, 32'h0,        32'h10, 1'b1, 32'h55AA55AA};
        vt[8] = '{1'b0, 32'h010, 32'h0,        32'h14, 1'b1, 32'hDEADBEEF};

        // Reset state
        tick(); tick();
        check("rst_ld_ready", ld_ready, 0);
        check("rst_hart_rst", hart_rst, 1);
        check("rst_instruction", instruction, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_cycles", cycles, 0);
        rst = 1'b0;
        #1;
        check("load_ld_ready", ld_ready, 1);
        check("load_hart_rst", hart_rst, 1);

        // Program load with a valid-low gap carrying junk
        ld_bytes = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        repeat (24) ld_bytes.push_back(8'($urandom));
        load_stream(5);
        check("imem0_const", u_dut.imem[0], 32'h00000013);
        check("imem1_const", u_dut.imem[1], 32'h00100093);
        for (int unsigned i = 0; i < 8; i++) check("imem_model", u_dut.imem[i], prog_m[i]);

        // Table-driven data/fetch vectors
        for (int unsigned i = 0; i < 9; i++) begin
            mem_write = vt[i].wr; mem_addr = vt[i].addr; mem_data = vt[i].data; pc = vt[i].pc;
            run_cycle();
            if (vt[i].wr) begin
                dmem_m[vt[i].addr[9:2]]     = vt[i].data;
                dmem_known[vt[i].addr[9:2]] = 1'b1;
            end
            check("vec_instr", instruction, prog_m[vt[i].pc >> 2]);
            if (vt[i].chk) check("vec_rd", mem_read, vt[i].exp_rd);
        end
        last_rd_m = vt[8].exp_rd;
        check("cycles_mid", cycles, cyc_m);

        // Randomized traffic against the model
        for (int unsigned n = 0; n < 300; n++) begin
            w  = $urandom_range(0, 15);
            p  = $urandom_range(0, 7);
            wr = ($urandom_range(0, 1) == 1) || !dmem_known[w];
            mem_write = wr; mem_addr = w * 4; mem_data = $urandom; pc = p * 4;
            run_cycle();
            if (wr) begin
                dmem_m[w] = mem_data;
                dmem_known[w] = 1'b1;
            end else begin
                last_rd_m = dmem_m[w];
            end
            check("rnd_instr", instruction, prog_m[p]);
            check("rnd_rd", mem_read, last_rd_m);
        end
        check("cycles_rnd", cycles, cyc_m);

`ifndef RISCV_MEMSYS_FAULT_EN
        // Index wrap and ignored low address bits
        mem_write = 1'b0; mem_addr = 32'h400; pc = WORDS * 4 + 4;
        run_cycle();
        check("wrap_rd", mem_read, dmem_m[0]);
        check("wrap_pc", instruction, prog_m[1]);
        mem_addr = 32'h13; pc = 32'h6;
        run_cycle();
        check("lowbits_rd", mem_read, dmem_m[4]);
        check("lowbits_pc", instruction, prog_m[1]);
        check("no_fault", fault, 0);
`endif

        // Halt write: no memory write, terminal state
        mem_write = 1'b1; mem_addr = HALT_ADDR; mem_data = 32'hFFFFFFFF; pc = '0;
        run_cycle();
        check("halt_done", done, 1);
        check("halt_hart_rst", hart_rst, 1);
        check("halt_cycles", cycles, cyc_m);
        check("halt_no_write", u_dut.dmem[255], 32'h55AA55AA);
        mem_addr = 32'h10; mem_data = 32'h0BADF00D;
        tick(); tick();
        mem_write = 1'b0;
        check("halt_cycles_hold", cycles, cyc_m);
        check("halt_instr_zero", instruction, 0);
        check("halt_done_sticky", done, 1);
        for (int unsigned i = 0; i < 16; i++)
            if (dmem_known[i]) check("halt_dmem", u_dut.dmem[i], dmem_m[i]);

        // Partial final word, then 10 RUN cycles + halt
        rst = 1'b1; tick(); rst = 1'b0;
        check("rerst_done", done, 0);
        ld_bytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load_stream(NO_GAP);
        check("pad_imem0", u_dut.imem[0], 32'h04030201);
        check("pad_imem1", u_dut.imem[1], 32'h00000005);
        check("dmem_kept", u_dut.dmem[4], dmem_m[4]);
        mem_write = 1'b0; mem_addr = '0; pc = '0;
        repeat (10) run_cycle();
        mem_write = 1'b1; mem_addr = HALT_ADDR;
        run_cycle();
        mem_write = 1'b0;
        check("halt11_cycles", cycles, 32'd11);
        check("halt11_done", done, 1);
        check("halt11_hart_rst", hart_rst, 1);

        // Reset mid-LOAD drops the partial word
        rst = 1'b1; tick(); rst = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hAA; tick();
        ld_data = 8'hBB; tick();
        ld_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        ld_bytes = {8'h77};
        load_stream(NO_GAP);
        check("midload_imem0", u_dut.imem[0], 32'h00000077);

        // Reset mid-RUN
        mem_addr = 32'h10; pc = '0;
        run_cycle(); run_cycle();
        check("prerst_rd", mem_read, dmem_m[4]);
        check("prerst_instr", instruction, 32'h00000077);
        rst = 1'b1; tick();
        check("midrun_instr", instruction, 0);
        check("midrun_rd", mem_read, 0);
        check("midrun_cycles", cycles, 0);
        check("midrun_done", done, 0);
        check("midrun_fault", fault, 0);
        check("midrun_hart_rst", hart_rst, 1);
        check("midrun_ld_ready", ld_ready, 0);
        rst = 1'b0;
        #1;
        check("midrun_load_state", ld_ready, 1);

        // Overflowing stream: extra bytes discarded, ld_last still honoured
        ld_bytes.delete();
        for (int unsigned i = 0; i < WORDS * 4 + 5; i++)
            ld_bytes.push_back(i < WORDS * 4 ? (8'(i) ^ 8'h3C) : 8'hEE);
        load_stream(NO_GAP);
        check("ovf_imem0", u_dut.imem[0], prog_m[0]);
        check("ovf_imem1", u_dut.imem[1], prog_m[1]);
        check("ovf_imem_last", u_dut.imem[WORDS-1], prog_m[WORDS-1]);
        pc = (WORDS - 1) * 4; mem_addr = '0;
        run_cycle();
        check("ovf_fetch", instruction, prog_m[WORDS-1]);

`ifdef RISCV_MEMSYS_FAULT_EN
        // Misaligned data access faults and halts
        mem_addr = 32'h402; pc = '0;
        run_cycle();
        check("fault_flag", fault, 1);
        check("fault_hart_rst", hart_rst, 1);
        check("fault_done", done, 0);
        tick();
        check("fault_cycles_hold", cycles, cyc_m);
        // Misaligned fetch faults
        rst = 1'b1; tick(); rst = 1'b0;
        ld_bytes = {8'h11, 8'h22, 8'h33, 8'h44};
        load_stream(NO_GAP);
        mem_addr = '0; pc = 32'h2;
        run_cycle();
        check("fault_pc", fault, 1);
        check("fault_pc_instr", instruction, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_memsys.md
RISCV_MEMSYS -- requirements
Module: riscv_memsys

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width of hart ports.
REQ-002 SHALL have parameter WORDS, default 256, depth of each of instruction and data memory (32-bit words, power of two).
REQ-003 SHALL have parameter HALT_ADDR, default 32'hFFFF_FFFC, data-port write address that ends the run.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on posedge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port ld_valid  in  1  loader byte valid.
REQ-007 SHALL have port ld_data  in  8  loader byte, little-endian within word.
REQ-008 SHALL have port ld_last  in  1  marks final loader byte.
REQ-009 SHALL have port ld_ready  out  1  loader byte accepted when ld_valid&&ld_ready.
REQ-010 SHALL have port hart_rst  out  1  reset driven to the hart.
REQ-011 SHALL have port pc  in  XLEN  hart fetch address (bytes).
REQ-012 SHALL have port instruction  out  32  fetched word.
REQ-013 SHALL have port mem_addr  in  XLEN  data byte address.
REQ-014 SHALL have port mem_data  in  XLEN  store data.
REQ-015 SHALL have port mem_write  in  1  store strobe, load otherwise.
REQ-016 SHALL have port mem_read  out  XLEN  load data.
REQ-017 SHALL have port done  out  1  sticky, halt write seen.
REQ-018 SHALL have port fault  out  1  sticky access fault.
REQ-019 SHALL have port cycles  out  32  RUN cycle count.

Function
REQ-020 SHALL implement FSM LOAD -> RUN -> HALT; LOAD entered from reset.
REQ-021 LOAD: ld_ready=1; each accepted byte placed at lane (byte count mod 4) of assembly word; word written to instr memory index (byte count div 4) when lane 3 filled or ld_last accepted.
REQ-022 Partial final word SHALL be zero-padded in unfilled upper lanes.
REQ-023 Bytes beyond WORDS*4 SHALL be accepted and discarded; ld_last still honoured.
REQ-024 Accepted ld_last SHALL move LOAD -> RUN next cycle; ld_ready=0 outside LOAD.
REQ-025 hart_rst SHALL be 1 in LOAD and HALT, 0 in RUN.
REQ-026 RUN: instruction SHALL register instr_mem[pc>>2] each cycle (1-cycle latency); 0 outside RUN.
REQ-027 RUN, mem_write=1, mem_addr!=HALT_ADDR: data_mem[mem_addr>>2] <= mem_data; mem_read holds.
REQ-028 RUN, mem_write=0: mem_read <= data_mem[mem_addr>>2] (1-cycle latency, read-before-write of no concern since single port).
REQ-029 RUN, mem_write=1 with mem_addr==HALT_ADDR: no memory write; done<=1; state -> HALT.
REQ-030 cycles SHALL increment once per RUN cycle, wrap at 2^32, hold in LOAD/HALT.
REQ-031 HALT SHALL be terminal until rst; memories retain contents, readable hierarchically.
REQ-032 Data memory SHALL NOT be cleared by reset or load.

Reset
REQ-033 rst SHALL force state LOAD, byte count 0, assembly word 0, instruction=0, mem_read=0, done=0, fault=0, cycles=0, hart_rst=1, ld_ready=0 during reset cycle.
REQ-034 rst mid-LOAD or mid-RUN SHALL abandon progress; a partially assembled word SHALL be dropped.

Configuration
REQ-035 Macro RISCV_MEMSYS_FAULT_EN SHALL, when defined, flag in RUN: pc[1:0]!=0, pc>>2 >= WORDS, or non-halt data access with mem_addr[1:0]!=0 or mem_addr>>2 >= WORDS; access suppressed, fault<=1, state -> HALT next cycle.
REQ-036 Without RISCV_MEMSYS_FAULT_EN: low address bits ignored, index wraps modulo WORDS, fault tied 0.

Verification
REQ-037 Load bytes 13 00 00 00 93 00 10 00 + ld_last -> instr[0]=0x00000013, instr[1]=0x00100093; hart_rst falls 1 cycle after ld_last.
REQ-038 Load 5 bytes 01..05 -> instr[1]=0x00000005 (zero-padded).
REQ-039 RUN, write 0xDEADBEEF to 0x10, then read 0x10 -> mem_read=0xDEADBEEF one cycle after read cycle.
REQ-040 RUN 10 cycles, then write to 0xFFFFFFFC -> done=1, hart_rst=1, cycles=11, data memory unchanged.
REQ-041 With FAULT_EN, read at 0x402 -> fault=1, HALT; without, read at 0x400 returns data_mem[0].
REQ-042 rst asserted mid-RUN -> all outputs at reset values next cycle, state LOAD.
